// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: controller state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/FULL_ADDER.sv
// Single-bit full adder cell; the serial adder iterates this once per clock.
module FULL_ADDER (
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic SUM,
    output logic CARRY
);

    assign SUM   = X ^ Y ^ Z;
    assign CARRY = (X & Y) | (Z & (X ^ Y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one FULL_ADDER plus a carry register, LSB first,
// with valid/ready handshakes on the operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | one sum bit per clock, cnt counts bits done
// DONE  | result held on sum/cout, out_valid high
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  s_sh;
    logic          c_reg;
    logic [CW-1:0] cnt;
    logic          fa_sum;
    logic          fa_carry;

    FULL_ADDER u_fa (
        .X     (a_sh[0]),
        .Y     (b_sh[0]),
        .Z     (c_reg),
        .SUM   (fa_sum),
        .CARRY (fa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)     next_state = SHIFT;
            SHIFT:   if (cnt == LAST)  next_state = DONE;
            DONE:    if (out_ready)    next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        s_sh  <= '0;
                        c_reg <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // sum bits enter at the top so bit 0 lands at s_sh[0] after W shifts
                    s_sh  <= {fa_sum, s_sh[W-1:1]};
                    a_sh  <= {1'b0, a_sh[W-1:1]};
                    b_sh  <= {1'b0, b_sh[W-1:1]};
                    c_reg <= fa_carry;
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = s_sh;
    assign cout      = c_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W=8 and W=13 instances) against
// plain integer addition.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, cin8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        iv13, ir13, ov13, or13, cin13, cout13;
    logic [12:0] a13, b13, sum13;

    int vectors = 0;
    int miscompares = 0;

    serial_adder #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(cout8)
    );

    serial_adder #(.W(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13),
        .a(a13), .b(b13), .cin(cin13), .out_valid(ov13), .out_ready(or13),
        .sum(sum13), .cout(cout13)
    );

    // Starts an 8-bit op from a negedge; returns at the first negedge with
    // out_valid high (or after a timeout), lat = edges after acceptance.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            iv8 = 1'b0;
            if (ov8) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic finish8();
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (ir8 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", ir8); end
        vectors++; if (ov8 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", ov8); end
        vectors++; if (sum8 !== 8'h00) begin miscompares++; $display("FAIL reset_sum got %h want 00", sum8); end
        vectors++; if (cout8 !== 1'b0) begin miscompares++; $display("FAIL reset_cout got %b want 0", cout8); end
    endtask

    task automatic test_basic();
        int lat;
        op8(8'h5A, 8'h3C, 1'b0, lat);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL basic_latency got %0d want 8", lat); end
        vectors++; if (sum8 !== 8'h96) begin miscompares++; $display("FAIL basic_sum got %h want 96", sum8); end
        vectors++; if (cout8 !== 1'b0) begin miscompares++; $display("FAIL basic_cout got %b want 0", cout8); end
        finish8();
        vectors++; if (ir8 !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready_after got %b want 1", ir8); end
    endtask

    task automatic test_carry();
        int lat;
        op8(8'hFF, 8'h01, 1'b0, lat);
        vectors++; if ({cout8, sum8} !== 9'h100) begin miscompares++; $display("FAIL carry_ff_01 got %b_%h want 1_00", cout8, sum8); end
        finish8();
        op8(8'hFF, 8'hFF, 1'b1, lat);
        vectors++; if ({cout8, sum8} !== 9'h1FF) begin miscompares++; $display("FAIL carry_ff_ff_1 got %b_%h want 1_ff", cout8, sum8); end
        finish8();
    endtask

    task automatic test_backpressure();
        int lat;
        op8(8'h37, 8'h44, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (ov8 !== 1'b1 || {cout8, sum8} !== 9'h07C) begin
                miscompares++;
                $display("FAIL backpressure_hold cyc %0d got ov=%b %b_%h want ov=1 0_7c", i, ov8, cout8, sum8);
            end
        end
        finish8();
        vectors++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin miscompares++; $display("FAIL backpressure_release got ov=%b ir=%b want ov=0 ir=1", ov8, ir8); end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
            if (ov8) break;
            @(posedge clk);
            lat++;
        end
        iv8 = 1'b0;
        vectors++; if ({cout8, sum8} !== 9'h003) begin miscompares++; $display("FAIL ignore_in_valid got %b_%h want 0_03", cout8, sum8); end
        finish8();
        @(posedge clk);
        @(negedge clk);
        vectors++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin miscompares++; $display("FAIL ignore_no_capture got ir=%b ov=%b want ir=1 ov=0", ir8, ov8); end
    endtask

    task automatic test_reset_abort();
        int lat;
        a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset_outputs got ir=%b ov=%b %b_%h want ir=1 ov=0 0_00", ir8, ov8, cout8, sum8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h10, 8'h20, 1'b0, lat);
        vectors++; if (lat !== 8 || {cout8, sum8} !== 9'h030) begin miscompares++; $display("FAIL abort_next_op got lat=%0d %b_%h want lat=8 0_30", lat, cout8, sum8); end
        finish8();
    endtask

    task automatic test_random8(input int n);
        logic [7:0] a, b;
        logic       c;
        logic [8:0] exp;
        int         t;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            exp = 9'(int'(a) + int'(b) + int'(c));
            if (!ir8) begin vectors++; miscompares++; $display("FAIL rand8_not_ready op %0d", i); end
            a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iv8 = 1'b0;
            t = 0;
            or8 = 1'($urandom);
            while (!(ov8 && or8) && t < 100) begin
                @(posedge clk);
                @(negedge clk);
                or8 = 1'($urandom);
                t++;
            end
            vectors++;
            if (t >= 100 || {cout8, sum8} !== exp) begin
                miscompares++;
                $display("FAIL rand8 op %0d a=%h b=%h cin=%b got %b_%h want %h t=%0d", i, a, b, c, cout8, sum8, exp, t);
            end
            @(posedge clk);
            @(negedge clk);
            or8 = 1'b0;
        end
    endtask

    task automatic test_random13(input int n);
        logic [12:0] a, b;
        logic        c;
        logic [13:0] exp;
        int          t;
        for (int i = 0; i < n; i++) begin
            a = 13'($urandom); b = 13'($urandom); c = 1'($urandom);
            exp = 14'(int'(a) + int'(b) + int'(c));
            if (!ir13) begin vectors++; miscompares++; $display("FAIL rand13_not_ready op %0d", i); end
            a13 = a; b13 = b; cin13 = c; iv13 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iv13 = 1'b0;
            t = 0;
            or13 = 1'($urandom);
            while (!(ov13 && or13) && t < 100) begin
                @(posedge clk);
                @(negedge clk);
                or13 = 1'($urandom);
                t++;
            end
            vectors++;
            if (t >= 100 || {cout13, sum13} !== exp) begin
                miscompares++;
                $display("FAIL rand13 op %0d a=%h b=%h cin=%b got %b_%h want %h t=%0d", i, a, b, c, cout13, sum13, exp, t);
            end
            @(posedge clk);
            @(negedge clk);
            or13 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        iv13 = 1'b0; or13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_carry();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_abort();
        test_random8(1000);
        test_random13(1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
